// File: rtl/mm_loader.sv
// mm_loader: streams 18 elements (A then B, row-major) into 3x3 operand buses. Optional MM_LOAD_LAST_EN adds in_last/err framing.
// Latency: out_valid one cycle after the 18th accept; in_ready returns one cycle after the pair is consumed.
// Backpressure: in_ready is low for the whole hold phase; the pair is held until out_ready.

module mm_loader (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [17:0]  in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [161:0] a_bits,
    output logic [161:0] b_bits
`ifdef MM_LOAD_LAST_EN
    ,
    input  logic         in_last,
    output logic         err
`endif
);

    localparam logic [0:0] ST_LOAD  = 1'b0;
    localparam logic [0:0] ST_HOLD  = 1'b1;
    localparam logic [4:0] K_LAST   = 5'd17;
    localparam logic [4:0] K_B_BASE = 5'd9;

    logic [0:0]  state;
    logic [4:0]  k;
    logic [17:0] a_mem [9];
    logic [17:0] b_mem [9];

    logic        accept;
    logic        consume;
    logic        at_last;
    logic        in_b;
    logic        frame_bad;
    logic        frame_done;
    logic [3:0]  a_idx;
    logic [3:0]  b_idx;

    assign in_ready  = (state == ST_LOAD);
    assign out_valid = (state == ST_HOLD);
    assign accept    = in_valid & in_ready;
    assign consume   = out_valid & out_ready;
    assign at_last   = (k == K_LAST);
    assign in_b      = (k >= K_B_BASE);
    assign a_idx     = k[3:0];
    // Modulo-16 subtract maps k=9..17 onto B slots 0..8 (k=16,17 wrap to 7,8).
    assign b_idx     = k[3:0] - 4'd9;

`ifdef MM_LOAD_LAST_EN
    assign frame_bad = accept & (in_last != at_last);
`else
    assign frame_bad = 1'b0;
`endif
    assign frame_done = accept & at_last & ~frame_bad;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_LOAD;
            k     <= 5'd0;
        end else if (consume) begin
            state <= ST_LOAD;
            k     <= 5'd0;
        end else if (frame_done) begin
            state <= ST_HOLD;
        end else if (frame_bad) begin
            k     <= 5'd0;
        end else if (accept) begin
            k     <= k + 5'd1;
        end
    end

    // Slots not yet overwritten keep the previous frame's values; out_valid qualifies them.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 9; i++) begin
                a_mem[i] <= '0;
                b_mem[i] <= '0;
            end
        end else if (accept) begin
            if (!in_b) begin
                a_mem[a_idx] <= in_data;
            end else begin
                b_mem[b_idx] <= in_data;
            end
        end
    end

`ifdef MM_LOAD_LAST_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err <= 1'b0;
        end else begin
            err <= frame_bad;
        end
    end
`endif

    for (genvar g = 0; g < 9; g++) begin : g_pack
        assign a_bits[g*18 +: 18] = a_mem[g];
        assign b_bits[g*18 +: 18] = b_mem[g];
    end

endmodule

// File: doc/mm_loader.md
MM_LOADER -- requirements
Module: mm_loader

Interface
REQ-001 SHALL have port: clk  input  1  single clock; all state updates on rising edge.
REQ-002 SHALL have port: rst_n  input  1  reset, asynchronous, active-low.
REQ-003 SHALL have port: in_valid  input  1  upstream element valid.
REQ-004 SHALL have port: in_ready  output  1  loader accepts an element this cycle.
REQ-005 SHALL have port: in_data  input  18  one unsigned matrix element.
REQ-006 SHALL have port: out_valid  output  1  a_bits/b_bits hold a complete A,B pair.
REQ-007 SHALL have port: out_ready  input  1  downstream 3x3 multiplier consumes the pair.
REQ-008 SHALL have port: a_bits  output  162  packed A, element (i,j) at bits [((i-1)*3+(j-1))*18+17 -:18], i,j in 1..3.
REQ-009 SHALL have port: b_bits  output  162  packed B, same packing as a_bits.
REQ-010 SHALL have ports, only when MM_LOAD_LAST_EN is defined: in_last  input  1  frame marker; err  output  1  framing-error pulse.

Function
REQ-011 SHALL accept one element per cycle when in_valid and in_ready are both 1 (handshake).
REQ-012 SHALL number accepted elements k = 0..17 with a 5-bit counter; k 0..8 = A row-major, k 9..17 = B row-major.
REQ-013 SHALL write element k<9 into a_bits slot k and element k>=9 into b_bits slot k-9, in the cycle after the handshake.
REQ-014 SHALL implement two states: LOAD (in_ready=1, out_valid=0) and HOLD (in_ready=0, out_valid=1).
REQ-015 SHALL move LOAD->HOLD on the handshake with k=17; out_valid SHALL rise the following cycle (latency 1 from last accept).
REQ-016 SHALL keep a_bits/b_bits stable throughout HOLD, whatever in_valid/in_data do.
REQ-017 SHALL move HOLD->LOAD with k reset to 0 on the cycle out_valid=1 and out_ready=1; in_ready SHALL rise the next cycle (one bubble per frame).
REQ-018 SHALL leave out_valid asserted indefinitely in HOLD until out_ready is 1; no timeout.
REQ-019 SHALL retain previous register contents in slots not yet overwritten during LOAD; out_valid=0 marks them invalid.
REQ-020 SHALL hold k and registers unchanged in cycles with in_valid=0 during LOAD (gaps allowed anywhere in a frame).
REQ-021 SHALL ignore out_ready while in LOAD.

Reset
REQ-022 SHALL, while rst_n=0, force state=LOAD, k=0, out_valid=0, a_bits=0, b_bits=0, err=0; in_ready=1 once state is LOAD.
REQ-023 SHALL discard any partial frame or held pair on reset asserted mid-operation; the first frame after reset starts at k=0.

Configuration
REQ-024 SHALL, with MM_LOAD_LAST_EN defined, check in_last on every handshake: error if in_last=1 with k!=17, or in_last=0 with k=17.
REQ-025 SHALL, on such an error, pulse err high for exactly one cycle, reset k to 0, stay in LOAD, and never assert out_valid for that frame.
REQ-026 SHALL, without MM_LOAD_LAST_EN, omit in_last and err entirely and delimit frames purely by count k=17.

Verification
REQ-027 SHALL pass: stream 0,1,...,8 then 1,2,...,9 back-to-back, out_ready=1 -> out_valid one cycle after 18th accept; a_bits slot0=0, slot8=8; b_bits slot0=1, slot8=9; downstream C(1,1)=18.
REQ-028 SHALL pass: same frame, out_ready=0 for 10 cycles then 1 -> out_valid held 11 cycles, in_ready=0 and buses unchanged throughout, in_ready=1 one cycle after the consuming cycle.
REQ-029 SHALL pass: frame with in_valid toggling 1/0 every cycle -> identical a_bits/b_bits as REQ-027, out_valid after 18th accept.
REQ-030 SHALL pass: rst_n pulsed low after 7 accepts, then full frame 100..117 -> a_bits slot0=100, b_bits slot8=117, no out_valid before 18 new accepts.
REQ-031 SHALL pass (MM_LOAD_LAST_EN): in_last=1 on accept k=5 -> err high exactly one cycle, no out_valid; following correct frame with in_last on k=17 -> normal out_valid, err stays 0.
